sim_uart_transmitter: RTL and testbench

//  Synthesizable 8N1 UART transmitter with a write FIFO. It serialises bytes

---
 rtl/sim_uart_transmitter.sv | 159 +++++++++++++++
 tb/tb_sim_uart_transmitter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sim_uart_transmitter.sv
// 8N1 UART transmitter with a circular write FIFO.
// Bytes leave LSB first; back-to-back frames have no idle gap.
module sim_uart_transmitter #(
    parameter int P_CLOCK_DIV    = 434,
    parameter int P_FIFO_DEPTH   = 16,
    parameter int P_FIFO_DEPTH_N = 4
) (
    input  logic                      iCLOCK,
    input  logic                      inRESET,
    input  logic                      iTX_REQ,
    input  logic [7:0]                iTX_DATA,
    output logic                      oTX_FULL,
    output logic                      oTX_EMPTY,
    output logic [P_FIFO_DEPTH_N:0]   oTX_COUNT,
    output logic                      oUART_TXD
);

    localparam int N  = P_FIFO_DEPTH_N;
    localparam int BW = (P_CLOCK_DIV > 1) ? $clog2(P_CLOCK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(P_CLOCK_DIV - 1);
    localparam logic [N:0]    DEPTH     = (N+1)'(P_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic [N:0]      count_q, count_d;
    logic [N-1:0]    wptr_q, wptr_d;
    logic [N-1:0]    rptr_q, rptr_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic [7:0]      mem_q [P_FIFO_DEPTH];
    logic            wr;
    logic            pop;
    logic            term;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        wr      = iTX_REQ && !full_q;
        term    = (baud_q == BAUD_LAST);

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (term) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (term) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (term) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        wptr_d = wr  ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;

        unique case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH);
        empty_d = (count_d == '0) && (state_d == IDLE);
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (wr) begin
            mem_q[wptr_q] <= iTX_DATA;
        end
    end

    assign oTX_FULL  = full_q;
    assign oTX_EMPTY = empty_q;
    assign oTX_COUNT = count_q;
    assign oUART_TXD = txd_q;

endmodule

// File: tb/tb_sim_uart_transmitter.sv
// Directed bench for sim_uart_transmitter at an 8-cycle bit time.
// Every serial bit is checked cycle by cycle against the 8N1 frame.
module tb_sim_uart_transmitter;

    localparam int DIV   = 8;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] data = 8'h00;
    logic       full;
    logic       empty;
    logic       txd;
    logic [4:0] count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sim_uart_transmitter #(
        .P_CLOCK_DIV    (DIV),
        .P_FIFO_DEPTH   (16),
        .P_FIFO_DEPTH_N (4)
    ) dut (
        .iCLOCK    (clk),
        .inRESET   (rst_n),
        .iTX_REQ   (req),
        .iTX_DATA  (data),
        .oTX_FULL  (full),
        .oTX_EMPTY (empty),
        .oTX_COUNT (count),
        .oUART_TXD (txd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        req  = 1'b1;
        data = b;
        tick();
        req  = 1'b0;
    endtask

    // Checks cycles first..FRAME-1 of a frame; stops in the last stop cycle
    task automatic rx_frame(input logic [7:0] b, input int first);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = first; k < FRAME; k++) begin
            check($sformatf("txd %02h c%0d", b, k), 32'(txd), 32'(f[k/DIV]));
            if (k != FRAME - 1) tick();
        end
    endtask

    initial begin
        logic [7:0] b;

        // reset held, then released
        repeat (3) tick();
        check("rst txd", 32'(txd), 1);
        check("rst empty", 32'(empty), 1);
        rst_n = 1'b1;
        tick();
        check("rel txd", 32'(txd), 1);
        check("rel empty", 32'(empty), 1);
        check("rel count", 32'(count), 0);
        check("rel full", 32'(full), 0);

        // single byte 0x55, one-cycle latency
        put(8'h55);
        check("lat txd", 32'(txd), 1);
        check("lat count", 32'(count), 1);
        check("lat empty", 32'(empty), 0);
        tick();
        check("pop count", 32'(count), 0);
        rx_frame(8'h55, 0);
        check("stop empty", 32'(empty), 0);
        tick();
        check("end empty", 32'(empty), 1);
        check("end txd", 32'(txd), 1);

        // three back-to-back frames
        put(8'h41);
        put(8'h42);
        put(8'h0A);
        check("abn count", 32'(count), 2);
        rx_frame(8'h41, 1);
        tick();
        rx_frame(8'h42, 0);
        tick();
        rx_frame(8'h0A, 0);
        tick();
        check("abn empty", 32'(empty), 1);

        // reset asserted mid-frame
        put(8'h00);
        put(8'h01);
        repeat (13) tick();
        check("pre rst txd", 32'(txd), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst txd", 32'(txd), 1);
        check("mid rst count", 32'(count), 0);
        check("mid rst empty", 32'(empty), 1);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3 * DIV; i++) begin
            tick();
            check("post rst txd", 32'(txd), 1);
        end
        check("post rst empty", 32'(empty), 1);

        // overfill while busy, write-on-pop at full and at count 5
        put(8'hAA);
        for (int i = 0; i <= 16; i++) begin
            put(8'(i));
            check($sformatf("fill cnt %0d", i), 32'(count),
                  (i < 16) ? i + 1 : 16);
            check($sformatf("fill full %0d", i), 32'(full),
                  (i >= 15) ? 1 : 0);
        end
        rx_frame(8'hAA, 16);
        req  = 1'b1;
        data = 8'hEE;
        tick();
        req  = 1'b0;
        check("wr@full count", 32'(count), 15);
        check("wr@full full", 32'(full), 0);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("drain cnt %0d", j), 32'(count),
                  (j <= 10) ? 15 - j : 16 - j);
            rx_frame(8'(j), 0);
            if (j == 10) begin
                req  = 1'b1;
                data = 8'h77;
            end
            tick();
            req = 1'b0;
        end
        rx_frame(8'h77, 0);
        tick();
        check("drain empty", 32'(empty), 1);
        check("drain count", 32'(count), 0);

        // pointer wrap with interleaved bursts
        for (int i = 0; i < 10; i++) put(8'(8'h30 + i));
        rx_frame(8'h30, 8);
        tick();
        for (int k = 1; k < 5; k++) begin
            rx_frame(8'(8'h30 + k), 0);
            tick();
        end
        check("wrap cnt a", 32'(count), 4);
        for (int i = 10; i < 18; i++) put(8'(8'h30 + i));
        check("wrap cnt b", 32'(count), 12);
        rx_frame(8'h35, 8);
        tick();
        for (int k = 6; k < 12; k++) begin
            rx_frame(8'(8'h30 + k), 0);
            tick();
        end
        check("wrap cnt c", 32'(count), 5);
        for (int i = 18; i < 24; i++) put(8'(8'h30 + i));
        check("wrap cnt d", 32'(count), 11);
        rx_frame(8'h3C, 6);
        tick();
        for (int k = 13; k < 24; k++) begin
            b = 8'(8'h30 + k);
            rx_frame(b, 0);
            tick();
        end
        check("wrap empty", 32'(empty), 1);
        check("wrap txd", 32'(txd), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
